ase_wr_responder: RTL and testbench

Host-side write-response generator for the ASE CCI-P model: consumes AFU write-channel requests (WrLine_I, WrLine_M, WrFence) and returns CCI-P Rx write responses after a fixed, parameterised latency, strictly in request order. It sits in the emulator between the AFU Tx channel-1 request path and the Rx channel-1 response path. It also drives the channel almost-full backpressure and sticky protocol-error flags.

---
 rtl/ase_wr_responder.sv | 174 +++++++++++++++++
 tb/tb_ase_wr_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ase_wr_responder.sv
// ase_wr_responder: CCI-P channel-1 write-response generator.
// Assembles write packets and replies in request order after RESP_LATENCY cycles.
module ase_wr_responder #(
    parameter int RESP_LATENCY   = 8,
    parameter int DEPTH          = 32,
    parameter int FULL_THRESHOLD = DEPTH - 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    input  logic [73:0] tx_hdr,
    output logic        tx_almfull,
    output logic        rx_valid,
    output logic [27:0] rx_hdr,
    output logic        proto_err,
    output logic        ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_MULTI = 1'b1;
    localparam logic [3:0]  T_WRI   = 4'd3;
    localparam logic [3:0]  T_WRM   = 4'd4;
    localparam logic [3:0]  T_FENCE = 4'd5;
    localparam logic [3:0]  R_WR    = 4'd2;
    localparam logic [3:0]  R_FENCE = 4'd4;
    localparam logic [AW:0] C_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_THR   = (AW+1)'(FULL_THRESHOLD);

    logic [1:0]    w_vc;
    logic          w_sop;
    logic [1:0]    w_len;
    logic [3:0]    w_type;
    logic [15:0]   w_mdata;
    logic          w_is_wr;
    logic          w_is_fence;
    logic          w_unused;

    logic [0:0]    r_state;
    logic [1:0]    r_left;
    logic [1:0]    r_l_vc;
    logic [15:0]   r_l_mdata;
    logic [1:0]    r_l_len;
    logic [15:0]   r_ts;
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic [36:0]   r_mem [DEPTH];

    logic          w_done;
    logic          w_perr;
    logic          w_latch;
    logic [0:0]    w_nstate;
    logic [1:0]    w_nleft;
    logic [1:0]    w_c_vc;
    logic [15:0]   w_c_mdata;
    logic [1:0]    w_c_len;
    logic          w_c_fence;
    logic [36:0]   w_entry;
    logic [36:0]   w_head;
    logic [15:0]   w_lag;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf;
    logic [1:0]    w_vc_used;
    logic          w_h_fence;
    logic [1:0]    w_h_len;
    logic [27:0]   w_rsp;

    assign w_vc       = tx_hdr[73:72];
    assign w_sop      = tx_hdr[71];
    assign w_len      = tx_hdr[69:68];
    assign w_type     = tx_hdr[67:64];
    assign w_mdata    = tx_hdr[15:0];
    assign w_is_wr    = (w_type == T_WRI) || (w_type == T_WRM);
    assign w_is_fence = (w_type == T_FENCE);
    assign w_unused   = ^{tx_hdr[70], tx_hdr[63:16]};

    always_comb begin
        w_done    = 1'b0;
        w_perr    = 1'b0;
        w_latch   = 1'b0;
        w_nstate  = r_state;
        w_nleft   = r_left;
        w_c_vc    = w_vc;
        w_c_mdata = w_mdata;
        w_c_len   = w_is_fence ? 2'd0 : w_len;
        w_c_fence = w_is_fence;
        if (tx_valid) begin
            if (!(w_is_wr || w_is_fence)) begin
                w_perr = 1'b1;
            end else if (r_state == S_IDLE) begin
                if (!w_sop) begin
                    w_perr = 1'b1;
                end else if (w_is_fence || w_len == 2'd0) begin
                    w_done = 1'b1;
                end else begin
                    w_latch  = 1'b1;
                    w_nleft  = w_len;
                    w_nstate = S_MULTI;
                end
            end else if (w_sop || w_is_fence) begin
                // Abort: the partially assembled packet is discarded.
                w_perr   = 1'b1;
                w_nstate = S_IDLE;
            end else begin
                w_nleft = r_left - 2'd1;
                if (r_left == 2'd1) begin
                    w_done    = 1'b1;
                    w_nstate  = S_IDLE;
                    w_c_vc    = r_l_vc;
                    w_c_mdata = r_l_mdata;
                    w_c_len   = r_l_len;
                    w_c_fence = 1'b0;
                end
            end
        end
    end

    assign w_entry = {w_c_vc, w_c_mdata, w_c_len, w_c_fence,
                      r_ts + 16'(RESP_LATENCY)};
    assign w_head  = r_mem[r_rp];
    // Wrap-safe: head is due once ts has reached its due stamp.
    assign w_lag   = r_ts - w_head[15:0];
    assign w_pop   = (r_count != '0) && !w_lag[15];
    assign w_push  = w_done && (r_count != C_FULL);
    assign w_ovf   = w_done && (r_count == C_FULL);

    assign w_h_fence = w_head[16];
    assign w_h_len   = w_h_fence ? 2'd0 : w_head[18:17];
    assign w_vc_used = (w_head[36:35] == 2'd0) ? 2'd1 : w_head[36:35];
    assign w_rsp     = {w_vc_used, 1'b0, 1'b0,
                        (!w_h_fence && w_h_len != 2'd0), 1'b0, w_h_len,
                        w_h_fence ? R_FENCE : R_WR, w_head[34:19]};

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= w_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_left     <= 2'd0;
            r_l_vc     <= 2'd0;
            r_l_mdata  <= 16'd0;
            r_l_len    <= 2'd0;
            r_ts       <= 16'd0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            tx_almfull <= 1'b0;
            rx_valid   <= 1'b0;
            rx_hdr     <= 28'd0;
            proto_err  <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_left  <= w_nleft;
            if (w_latch) begin
                r_l_vc    <= w_vc;
                r_l_mdata <= w_mdata;
                r_l_len   <= w_len;
            end
            r_ts <= r_ts + 16'd1;
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_count    <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            tx_almfull <= (r_count >= C_THR);
            rx_valid   <= w_pop;
            if (w_pop)  rx_hdr    <= w_rsp;
            if (w_perr) proto_err <= 1'b1;
            if (w_ovf)  ovf_err   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ase_wr_responder.sv
// Bench for ase_wr_responder: two instances (latency 8 and 40) share stimulus
// and are checked every cycle against a queue-based response model.
module tb_ase_wr_responder;
    localparam int DEPTH = 32;
    localparam int TH    = DEPTH - 5;
    localparam int L0    = 8;
    localparam int L1    = 40;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tx_valid = 1'b0;
    logic [73:0]      tx_hdr = '0;
    logic [1:0]       alm;
    logic [1:0]       rxv;
    logic [1:0]       perr;
    logic [1:0]       ovf;
    logic [1:0][27:0] rxh;

    int n_cmp = 0;
    int n_bad = 0;
    int nrsp [2] = '{0, 0};

    always #5 clk = ~clk;

    ase_wr_responder #(.RESP_LATENCY(L0), .DEPTH(DEPTH)) u_d0 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_hdr(tx_hdr),
        .tx_almfull(alm[0]), .rx_valid(rxv[0]), .rx_hdr(rxh[0]),
        .proto_err(perr[0]), .ovf_err(ovf[0]));

    ase_wr_responder #(.RESP_LATENCY(L1), .DEPTH(DEPTH)) u_d1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_hdr(tx_hdr),
        .tx_almfull(alm[1]), .rx_valid(rxv[1]), .rx_hdr(rxh[1]),
        .proto_err(perr[1]), .ovf_err(ovf[1]));

    // Model: pending responses per instance, each with an absolute due cycle.
    int          mdue [2][64];
    logic [27:0] mrsp [2][64];
    int          mh [2];
    int          mn [2];
    int          cyc;
    int          m_left;
    logic [27:0] m_rsp;
    logic [1:0]  e_rxv;
    logic [27:0] e_rxh [2];
    logic [1:0]  e_alm;
    logic        e_perr;
    logic [1:0]  e_ovf;

    function automatic logic [27:0] rsp_of(logic [1:0] vc, logic [1:0] len,
                                           logic fence, logic [15:0] md);
        logic [1:0] vu;
        vu = (vc == 2'd0) ? 2'd1 : vc;
        if (fence) return {vu, 4'b0000, 2'd0, 4'd4, md};
        return {vu, 2'b00, (len != 2'd0), 1'b0, len, 4'd2, md};
    endfunction

    function automatic logic [73:0] mk(logic [1:0] vc, logic sop,
                                       logic [1:0] len, logic [3:0] typ,
                                       logic [15:0] md);
        logic [41:0] addr;
        addr = {10'($urandom), 32'($urandom)};
        return {vc, sop, 1'b0, len, typ, 6'b0, addr, md};
    endfunction

    task automatic model_step();
        logic        done;
        logic [27:0] crsp;
        logic [3:0]  typ;
        logic [1:0]  vc;
        logic [1:0]  len;
        logic        sop;
        int          occ;
        if (rst) begin
            mh = '{0, 0};
            mn = '{0, 0};
            cyc = 0;
            m_left = 0;
            e_rxv = '0;
            e_rxh = '{28'd0, 28'd0};
            e_alm = '0;
            e_perr = 1'b0;
            e_ovf = '0;
            return;
        end
        done = 1'b0;
        crsp = '0;
        typ = tx_hdr[67:64];
        vc  = tx_hdr[73:72];
        len = tx_hdr[69:68];
        sop = tx_hdr[71];
        if (tx_valid) begin
            if (!(typ inside {4'd3, 4'd4, 4'd5})) begin
                e_perr = 1'b1;
            end else if (m_left == 0) begin
                if (!sop) e_perr = 1'b1;
                else if (typ == 4'd5) begin
                    done = 1'b1;
                    crsp = rsp_of(vc, 2'd0, 1'b1, tx_hdr[15:0]);
                end else if (len == 2'd0) begin
                    done = 1'b1;
                    crsp = rsp_of(vc, 2'd0, 1'b0, tx_hdr[15:0]);
                end else begin
                    m_left = int'(len);
                    m_rsp = rsp_of(vc, len, 1'b0, tx_hdr[15:0]);
                end
            end else if (sop || typ == 4'd5) begin
                e_perr = 1'b1;
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    done = 1'b1;
                    crsp = m_rsp;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            occ = mn[i];
            e_alm[i] = (occ >= TH);
            e_rxv[i] = 1'b0;
            if (mn[i] > 0 && cyc >= mdue[i][mh[i]]) begin
                e_rxv[i] = 1'b1;
                e_rxh[i] = mrsp[i][mh[i]];
                mh[i] = (mh[i] + 1) % 64;
                mn[i]--;
            end
            if (done) begin
                if (occ >= DEPTH) e_ovf[i] = 1'b1;
                else begin
                    mdue[i][(mh[i] + mn[i]) % 64] = cyc + ((i == 0) ? L0 : L1);
                    mrsp[i][(mh[i] + mn[i]) % 64] = crsp;
                    mn[i]++;
                end
            end
        end
        cyc++;
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] @%0t: got %h want %h", nm, idx, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rx_valid", i, 32'(rxv[i]), 32'(e_rxv[i]));
            chk("rx_hdr", i, 32'(rxh[i]), 32'(e_rxh[i]));
            chk("tx_almfull", i, 32'(alm[i]), 32'(e_alm[i]));
            chk("proto_err", i, 32'(perr[i]), 32'(e_perr));
            chk("ovf_err", i, 32'(ovf[i]), 32'(e_ovf[i]));
            if (rxv[i]) nrsp[i]++;
        end
    end

    task automatic beat(input logic [73:0] h);
        @(negedge clk);
        rst = 1'b0;
        tx_valid = 1'b1;
        tx_hdr = h;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int b0;
        int b1;
        logic [3:0] tt [8];
        tt = '{4'd3, 4'd4, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2, 4'd0};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_outs", i, {27'd0, alm[i], rxv[i], perr[i], ovf[i],
                rxh[i] != 28'd0}, 32'd0);
        end
        rst = 1'b0;
        idle(2);

        // Single WRLINE_I on VA, len 0
        beat(mk(2'd0, 1'b1, 2'd0, 4'd3, 16'h1234));
        idle(1);
        wait_edges(7);
        chk("t1_early", 0, 32'(rxv[0]), 32'd0);
        wait_edges(1);
        chk("t1_valid", 0, 32'(rxv[0]), 32'd1);
        chk("t1_hdr", 0, 32'(rxh[0]), 32'h4021234);
        idle(45);

        // Four-beat WRLINE_M packet
        beat(mk(2'd2, 1'b1, 2'd3, 4'd4, 16'h00AA));
        for (int k = 0; k < 3; k++) beat(mk(2'd0, 1'b0, 2'd0, 4'd4, 16'h5555));
        idle(1);
        b0 = nrsp[0];
        wait_edges(7);
        chk("t2_early", 0, 32'(nrsp[0] - b0), 32'd0);
        wait_edges(1);
        chk("t2_valid", 0, 32'(rxv[0]), 32'd1);
        chk("t2_hdr", 0, 32'(rxh[0]), 32'h8B200AA);
        idle(45);
        chk("t2_count", 0, 32'(nrsp[0] - b0), 32'd1);

        // Writes 1,2,3 then fence 4
        for (int k = 1; k <= 3; k++) beat(mk(2'd1, 1'b1, 2'd0, 4'd3, 16'(k)));
        beat(mk(2'd1, 1'b1, 2'd2, 4'd5, 16'd4));
        idle(1);
        wait_edges(5);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) wait_edges(1);
            chk("t3_valid", j, 32'(rxv[0]), 32'd1);
            chk("t3_mdata", j, 32'(rxh[0][15:0]), 32'(j + 1));
            chk("t3_type", j, 32'(rxh[0][19:16]), (j == 3) ? 32'd4 : 32'd2);
        end
        idle(45);

        // 33 back-to-back writes: the slow instance fills and overflows
        b0 = nrsp[0];
        b1 = nrsp[1];
        for (int k = 0; k < 33; k++) beat(mk(2'd3, 1'b1, 2'd0, 4'd3, 16'(100 + k)));
        idle(1);
        chk("t4_almfull", 1, 32'(alm[1]), 32'd1);
        chk("t4_ovf", 1, 32'(ovf[1]), 32'd1);
        chk("t4_ovf", 0, 32'(ovf[0]), 32'd0);
        idle(80);
        chk("t4_rsps", 1, 32'(nrsp[1] - b1), 32'd32);
        chk("t4_rsps", 0, 32'(nrsp[0] - b0), 32'd33);

        // Bad sop and a read type
        chk("t5_perr_pre", 0, 32'(perr[0]), 32'd0);
        b0 = nrsp[0];
        beat(mk(2'd0, 1'b0, 2'd0, 4'd3, 16'h0BAD));
        beat(mk(2'd0, 1'b1, 2'd0, 4'd1, 16'h0BAD));
        idle(1);
        chk("t5_perr", 0, 32'(perr[0]), 32'd1);
        idle(50);
        chk("t5_none", 0, 32'(nrsp[0] - b0), 32'd0);
        beat(mk(2'd1, 1'b1, 2'd0, 4'd4, 16'h0600));
        idle(50);
        chk("t5_after", 0, 32'(nrsp[0] - b0), 32'd1);

        // Reset between beats 2 and 3 of a len=3 packet
        beat(mk(2'd1, 1'b1, 2'd3, 4'd3, 16'h0777));
        beat(mk(2'd1, 1'b0, 2'd0, 4'd3, 16'h0000));
        @(negedge clk);
        rst = 1'b1;
        tx_valid = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("t6_rst_outs", i, {27'd0, alm[i], rxv[i], perr[i], ovf[i],
                rxh[i] != 28'd0}, 32'd0);
        end
        b0 = nrsp[0];
        beat(mk(2'd1, 1'b0, 2'd0, 4'd3, 16'h0000));
        beat(mk(2'd1, 1'b0, 2'd0, 4'd3, 16'h0000));
        idle(1);
        chk("t6_perr", 0, 32'(perr[0]), 32'd1);
        idle(50);
        chk("t6_none", 0, 32'(nrsp[0] - b0), 32'd0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                tx_valid = 1'b0;
            end else begin
                rst = 1'b0;
                tx_valid = ($urandom_range(0, 9) < 6);
                tx_hdr = mk(2'($urandom), ($urandom_range(0, 3) != 0),
                            2'($urandom), tt[$urandom_range(0, 7)],
                            16'($urandom));
            end
        end
        for (int c = 0; c < 60; c++) beat(mk(2'($urandom), 1'b1, 2'd0, 4'd4, 16'($urandom)));
        idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
